// File: rtl/cart_bus_arbiter_pkg.sv
// Shared cart-port types: bank direction and arbiter state encoding.
package pocket;

    typedef enum logic [0:0] {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_TURN    = 2'd1,
        ARB_OWN     = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cart_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after ptr_i wins.
module rr_picker #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    // Scan from ptr_i+1 around the ring and keep the first hit.
    always_comb begin
        int   idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/cart_bus_arbiter.sv
// Cart pin-bank owner arbiter with direction sequencing and turnaround dead cycles.
// Optional grant watchdog enabled by defining CART_BUS_ARB_TIMEOUT_EN.
module cart_bus_arbiter
    import pocket::*;
#(
    parameter int WIDTH       = 8,
    parameter int N_REQ       = 2,
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_wr,
    input  logic [N_REQ*WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]       grant,
    output dir_e                   bus_dir,
    output logic [WIDTH-1:0]       bus_dout,
    input  logic [WIDTH-1:0]       bus_din,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rdata_valid,
    output logic                   timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]  owner_q, owner_d;
    logic              own_wr_q, own_wr_d;
    logic              prev_wr_q, prev_wr_d;
    logic              fresh_q, fresh_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic [N_REQ-1:0]  grant_q;
    dir_e              dir_q;
    logic [WIDTH-1:0]  rdata_q;
    logic              rdata_valid_q;
    logic [N_REQ-1:0]  pick_s;
    logic [N_REQ-1:0]  mask_s;
    logic              revoke_s;

    rr_picker #(.N(N_REQ)) u_pick (
        .req_i (req & ~mask_s),
        .ptr_i (ptr_q),
        .gnt_o (pick_s)
    );

`ifdef CART_BUS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0]    hold_q;
    logic [N_REQ-1:0] blocked_q;

    assign revoke_s = (state_q == ARB_OWN) && (hold_q == HW'(MAX_HOLD - 1));
    assign mask_s   = blocked_q;

    // Hold watchdog; a revoked owner stays masked until it drops req.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= '0;
            blocked_q <= '0;
        end else begin
            hold_q    <= (state_q == ARB_OWN && !revoke_s) ? hold_q + HW'(1) : '0;
            blocked_q <= (blocked_q & req) | (timeout_d ? owner_q : '0);
        end
    end
`else
    assign revoke_s = 1'b0;
    assign mask_s   = '0;
`endif

    // Next-state logic; a reader right after reset or after another reader skips the turnaround.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        own_wr_d  = own_wr_q;
        prev_wr_d = prev_wr_q;
        fresh_d   = fresh_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = 4'd0;
                if (|pick_s) begin
                    owner_d  = pick_s;
                    own_wr_d = |(req_wr & pick_s);
                    ptr_d    = PW'(onehot_to_idx(8'(pick_s)));
                    fresh_d  = 1'b0;
                    if (own_wr_d || (prev_wr_q && !fresh_q)) begin
                        state_d = ARB_TURN;
                    end else begin
                        state_d = ARB_OWN;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_TURN: begin
                if (cnt_q == 4'(TURN_CYCLES - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = ARB_OWN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ARB_OWN: begin
                if (!(|(req & owner_q))) begin
                    state_d   = ARB_RELEASE;
                    prev_wr_d = own_wr_q;
                end else if (revoke_s) begin
                    state_d   = ARB_RELEASE;
                    prev_wr_d = own_wr_q;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ARB_OWN;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            ptr_q         <= PW'(N_REQ - 1);
            owner_q       <= '0;
            own_wr_q      <= 1'b0;
            prev_wr_q     <= 1'b1;
            fresh_q       <= 1'b1;
            cnt_q         <= 4'd0;
            timeout_q     <= 1'b0;
            grant_q       <= '0;
            dir_q         <= DIR_IN;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            own_wr_q      <= own_wr_d;
            prev_wr_q     <= prev_wr_d;
            fresh_q       <= fresh_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
            grant_q       <= (state_d == ARB_OWN) ? owner_d : '0;
            dir_q         <= (state_d == ARB_OWN && own_wr_d) ? DIR_OUT : DIR_IN;
            rdata_q       <= bus_din;
            rdata_valid_q <= (state_q == ARB_OWN) && !own_wr_q;
        end
    end

    // Write data flows through in the same cycle; forced to zero unless driving.
    always_comb begin
        bus_dout = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (dir_q == DIR_OUT && owner_q[i]) begin
                bus_dout = bus_dout | req_wdata[i*WIDTH +: WIDTH];
            end else begin
                bus_dout = bus_dout;
            end
        end
    end

    assign grant       = grant_q;
    assign bus_dir     = dir_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Scoreboard bench for cart_bus_arbiter; owner order is queued as requests are driven.
module tb_cart_bus_arbiter;
    import pocket::*;

    localparam int WIDTH = 8;
    localparam int N_REQ = 2;
    localparam int TURN  = 2;
`ifdef CART_BUS_ARB_TIMEOUT_EN
    localparam int HOLD = 16;
`else
    localparam int HOLD = 1024;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ-1:0]       req_wr = '0;
    logic [N_REQ*WIDTH-1:0] req_wdata = '0;
    logic [N_REQ-1:0]       grant;
    dir_e                   bus_dir;
    logic [WIDTH-1:0]       bus_dout;
    logic [WIDTH-1:0]       bus_din = '0;
    logic [WIDTH-1:0]       rdata;
    logic                   rdata_valid;
    logic                   timeout;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int gap = 0;
    bit seen_out = 1'b0;
    bit prev_out = 1'b0;

    cart_bus_arbiter #(
        .WIDTH(WIDTH), .N_REQ(N_REQ), .TURN_CYCLES(TURN), .MAX_HOLD(HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
        .req_wdata(req_wdata), .grant(grant), .bus_dir(bus_dir),
        .bus_dout(bus_dout), .bus_din(bus_din), .rdata(rdata),
        .rdata_valid(rdata_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Bus-safety monitor: one-hot grant, quiet dout when reading, dead gap between drivers.
    always @(negedge clk) begin
        if (!reset_n) begin
            gap = 0;
            seen_out = 1'b0;
            prev_out = 1'b0;
        end else begin
            checks++;
            if ($countones(grant) > 1 || (bus_dir == DIR_IN && bus_dout !== 8'h00)) begin
                errors++;
                $display("FAIL bus_safety: grant=%b dir=%0d dout=%h, required one-hot and dout=0 when DIR_IN",
                         grant, bus_dir, bus_dout);
            end
            if (bus_dir == DIR_OUT) begin
                if (!prev_out && seen_out) begin
                    checks++;
                    if (gap < TURN + 1) begin
                        errors++;
                        $display("FAIL turn_gap: got %0d DIR_IN cycles, required >= %0d", gap, TURN + 1);
                    end
                end
                seen_out = 1'b1;
                prev_out = 1'b1;
                gap = 0;
            end else begin
                prev_out = 1'b0;
                gap++;
            end
        end
    end

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                idx = (grant == 2'b10) ? 1 : 0;
                break;
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: grant=%b after 64 cycles, required nonzero", grant);
        end
    endtask

    task automatic check_owner(input int idx);
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
        checks++;
        if (idx !== e) begin
            errors++;
            $display("FAIL owner_order: got %0d, required %0d", idx, e);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 2'b11;
        req_wr = 2'b11;
        bus_din = 8'h77;
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 2'b00 || bus_dir !== DIR_IN || bus_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: grant=%b dir=%0d dout=%h, required 00/IN/00", grant, bus_dir, bus_dout);
        end
        checks++;
        if (rdata !== 8'h00 || rdata_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_read: rdata=%h valid=%b timeout=%b, required 00/0/0", rdata, rdata_valid, timeout);
        end
        req = 2'b00;
        req_wr = 2'b00;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int idx;
        req_wdata = {8'h22, 8'h11};
        req_wr = 2'b11;
        req = 2'b11;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        for (int k = 0; k < 3; k++) begin
            wait_grant(idx);
            if (idx < 0) break;
            check_owner(idx);
            checks++;
            if (bus_dir !== DIR_OUT || bus_dout !== ((idx == 0) ? 8'h11 : 8'h22)) begin
                errors++;
                $display("FAIL rr_drive: dir=%0d dout=%h for owner %0d", bus_dir, bus_dout, idx);
            end
            @(negedge clk);
            req[idx] = 1'b0;
            @(negedge clk);
            checks++;
            if (grant !== 2'b00) begin
                errors++;
                $display("FAIL rr_drop: grant=%b, required 00", grant);
            end
            if (k < 2) req[idx] = 1'b1;
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_writer();
        req_wdata = {8'h00, 8'hA5};
        req_wr = 2'b01;
        req = 2'b01;
        exp_q.push_back(0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (grant !== 2'b00 || bus_dir !== DIR_IN) begin
                errors++;
                $display("FAIL sw_turn: grant=%b dir=%0d, required 00/IN", grant, bus_dir);
            end
        end
        @(negedge clk);
        check_owner((grant == 2'b01) ? 0 : -1);
        checks++;
        if (bus_dir !== DIR_OUT || bus_dout !== 8'hA5) begin
            errors++;
            $display("FAIL sw_drive: dir=%0d dout=%h, required OUT/a5", bus_dir, bus_dout);
        end
        req_wdata = {8'h00, 8'h5A};
        #1;
        checks++;
        if (bus_dout !== 8'h5A) begin
            errors++;
            $display("FAIL sw_passthru: dout=%h, required 5a", bus_dout);
        end
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || bus_dir !== DIR_IN || bus_dout !== 8'h00) begin
            errors++;
            $display("FAIL sw_release: grant=%b dir=%0d dout=%h, required 00/IN/00", grant, bus_dir, bus_dout);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reader_after_reader();
        int idx;
        int c;
        bus_din = 8'h3C;
        req_wr = 2'b00;
        req = 2'b10;
        exp_q.push_back(1);
        wait_grant(idx);
        check_owner(idx);
        @(negedge clk);
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== 8'h3C || bus_dir !== DIR_IN) begin
            errors++;
            $display("FAIL rd_sample: valid=%b rdata=%h dir=%0d, required 1/3c/IN", rdata_valid, rdata, bus_dir);
        end
        req = 2'b01;
        exp_q.push_back(0);
        c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (grant == 2'b01) begin
                c = i;
                break;
            end
        end
        check_owner((grant == 2'b01) ? 0 : -1);
        checks++;
        if (c !== 3) begin
            errors++;
            $display("FAIL rd_no_turn: handover took %0d cycles, required 3", c);
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int idx;
        req_wdata = {8'h22, 8'h11};
        req_wr = 2'b11;
        req = 2'b10;
        wait_grant(idx);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_dir !== DIR_IN || grant !== 2'b00 || bus_dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: dir=%0d grant=%b dout=%h, required IN/00/00", bus_dir, grant, bus_dout);
        end
        req = 2'b11;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(0);
        wait_grant(idx);
        check_owner(idx);
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask

`ifdef CART_BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int idx;
        int n;
        req_wr = 2'b00;
        req = 2'b11;
        exp_q.push_back(0);
        wait_grant(idx);
        check_owner(idx);
        n = 0;
        while (grant == 2'b01 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== HOLD || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: owned %0d cycles timeout=%b, required %0d/1", n, timeout, HOLD);
        end
        exp_q.push_back(1);
        wait_grant(idx);
        check_owner(idx);
        req[1] = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (grant == 2'b01) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL to_block: blocked owner granted %0d cycles, required 0", n);
        end
        req = 2'b00;
        @(negedge clk);
        req = 2'b01;
        exp_q.push_back(0);
        wait_grant(idx);
        check_owner(idx);
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask
`else
    task automatic test_timeout();
        int idx;
        int bad;
        req_wr = 2'b00;
        req = 2'b01;
        exp_q.push_back(0);
        wait_grant(idx);
        check_owner(idx);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (timeout !== 1'b0 || grant !== 2'b01) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL no_timeout: %0d bad cycles, required 0", bad);
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_single_writer();
        test_reader_after_reader();
        test_reset_mid_write();
        test_timeout();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cart_bus_arbiter.md
# cart_bus_arbiter

Arbitrates ownership of one shared bidirectional Pocket cartridge pin bank between N requesters and sequences its direction. Drives the `dir` and `data_out` inputs of that bank's tristate buffer, and inserts bus-turnaround dead cycles so that no two drivers ever overlap. It sits between the core's cart-port clients (for example the link-cable engine and the cart-bus master) and the pin-level tristate buffer.

## Interface
- `WIDTH`, 8: bank width in bits.
- `N_REQ`, 2: number of requesters, 2..8.
- `TURN_CYCLES`, 2: dead cycles with `dir`=DIR_IN inserted at every turnaround, 1..15.
- `MAX_HOLD`, 1024: watchdog limit in cycles; used only with the timeout feature.

Ports:
- `clk` input 1: single clock, all logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input N_REQ: request per requester; held high for the whole transaction.
- `req_wr` input N_REQ: 1 means the requester will drive the bus, 0 means it reads. Sampled at grant.
- `req_wdata` input N_REQ*WIDTH: write data, packed with requester i at bits [i*WIDTH +: WIDTH].
- `grant` output N_REQ: one-hot current owner, or zero.
- `bus_dir` output pocket::dir_e: to the tristate buffer `dir`.
- `bus_dout` output WIDTH: to the tristate buffer `data_out`.
- `bus_din` input WIDTH: resolved pin value from the tristate buffer `data_in`.
- `rdata` output WIDTH: registered `bus_din`.
- `rdata_valid` output 1: `rdata` holds a sample taken while the owner is a reader.
- `timeout` output 1: one-cycle pulse when the watchdog revokes a grant. Tied to 0 when the timeout feature is compiled out.

## Operation
- The state machine has four states, defined in `pocket::arb_state_e`: ARB_IDLE, ARB_TURN, ARB_OWN, ARB_RELEASE.
- Round-robin arbitration:
  - The pointer starts after the last granted index, lowest index first.
  - The pointer resets to index N_REQ-1, so requester 0 wins first.
- State transitions:
  - ARB_IDLE with any `req` high: pick a winner and latch its `req_wr` as `own_wr`.
    - If the previous owner wrote, or the new owner writes: go to ARB_TURN.
    - Otherwise (reader after reader, or the first reader after reset): go directly to ARB_OWN.
  - ARB_TURN: `bus_dir`=DIR_IN, `grant`=0, counter runs TURN_CYCLES. On expiry: ARB_OWN.
  - ARB_OWN: `grant` is one-hot for the owner.
    - If `own_wr`=1: `bus_dir`=DIR_OUT and `bus_dout` = the owner's `req_wdata`, passed through combinationally from the current cycle.
    - If `own_wr`=0: `bus_dir`=DIR_IN.
  - ARB_OWN with the owner's `req` low: go to ARB_RELEASE.
  - ARB_RELEASE: `grant`=0, `bus_dir`=DIR_IN for one cycle, then go to ARB_IDLE.
- `req_wr` changes during ownership are ignored. A requester changes direction by dropping `req` and re-requesting.
- `bus_dout` is 0 whenever `bus_dir`=DIR_IN.
- `rdata` is registered every cycle from `bus_din`.
- `rdata_valid` is high when the previous cycle was ARB_OWN with `own_wr`=0.
- Simultaneous requests: round-robin order decides. A requester that drops `req` in the same cycle it would have been picked is not granted.
- A new request arriving during ARB_TURN or ARB_RELEASE waits. The winner was already chosen in ARB_IDLE.

## Timing
- Reset values:
  - State ARB_IDLE.
  - `grant`=0, `bus_dir`=DIR_IN, `bus_dout`=0.
  - `rdata`=0, `rdata_valid`=0, `timeout`=0.
  - Previous-owner-wrote flag = 1, so the first writer gets a turnaround.
- Reset asserted mid-transaction returns `bus_dir` to DIR_IN immediately (asynchronously). No glitch to DIR_OUT is permitted.
- Grant latency from ARB_IDLE, counting from the `req` rising edge to `grant` high:
  - No turnaround: 2 cycles.
  - With turnaround: TURN_CYCLES+2 cycles.
- Drop of `req` to `grant` low: 1 cycle.
- Minimum bus-idle gap between two driving owners: TURN_CYCLES+1 cycles.

## Configuration
- `CART_BUS_ARB_TIMEOUT_EN` defined:
  - A hold counter runs in ARB_OWN.
  - When it reaches MAX_HOLD, the grant is revoked: go to ARB_RELEASE, pulse `timeout`, and advance the round-robin pointer past the offender.
  - The offender must drop `req` before it can be granted again.
- Not defined: no counter, ownership is unlimited, and `timeout` is constant 0.

## Structure
- Package `pocket`:
  - Add `arb_state_e`.
  - Reuse `dir_e`.
- Sub-module `rr_picker`: combinational round-robin one-hot picker.
  - Parameter N.
  - Inputs: request vector, pointer.
  - Output: one-hot grant.

## Test plan
- Reset: hold `reset_n`=0 with `req`=2'b11 → `grant`=0, `bus_dir`=DIR_IN, `bus_dout`=0.
- Single writer, TURN_CYCLES=2: `req`[0]=1, `req_wr`[0]=1, wdata 8'hA5 → `grant`=01 at cycle 4 with `bus_dir`=DIR_OUT and `bus_dout`=A5. Drop `req` → `grant`=0 and DIR_IN the next cycle.
- Reader after reader: drive `bus_din`=8'h3C while requester 1 reads, then requester 0 reads → no ARB_TURN between the two owners, and `rdata_valid`=1 with `rdata`=3C.
- Writer then writer, round-robin: `req`=11 both writing → order 0,1,0. Each handover shows at least TURN_CYCLES+1 cycles of DIR_IN and never two grant bits high.
- Reset mid-write: pulse `reset_n` low while in ARB_OWN as a writer → `bus_dir`=DIR_IN in the same cycle, and after reset the first grant goes to requester 0.
- With CART_BUS_ARB_TIMEOUT_EN and MAX_HOLD=16: requester 0 holds `req` indefinitely → `timeout` pulses after 16 cycles of ownership, and requester 1 is granted next.
